// File: rtl/viterbi_pkg.sv
// Code parameters and types shared by the K=3 encoder and the Viterbi decoder's
// branch-metric units.
package viterbi_pkg;

   localparam int         K  = 3;
   localparam logic [2:0] G0 = 3'b111;
   localparam logic [2:0] G1 = 3'b101;

   typedef enum logic {
      ST_DATA = 1'b0,
      ST_TAIL = 1'b1
   } enc_state_e;

   typedef logic [1:0] sym_t;

   // Modulo-2 sum of the window bits selected by a generator polynomial.
   function automatic logic gen_parity(input logic [2:0] taps, input logic [2:0] win);
      return ^(taps & win);
   endfunction

endpackage

// File: rtl/enc_branch.sv
// One trellis branch of the K=3 code: coded symbol and successor state for input d.
module enc_branch
   import viterbi_pkg::*;
(
   input  logic [1:0] sr,
   input  logic       d,
   output sym_t       sym,
   output logic [1:0] sr_next
);

   // Window is {d, s1, s0}, so generator bit 2 taps the newest bit.
   logic [2:0] win;

   assign win     = {d, sr};
   assign sym     = {gen_parity(G0, win), gen_parity(G1, win)};
   assign sr_next = {d, sr[1]};

endmodule

// File: rtl/conv_encoder_k3.sv
// Frame-based rate-1/2 K=3 convolutional encoder with two zero tail bits per
// frame and a single registered output slot under valid/ready flow control.
module conv_encoder_k3
   import viterbi_pkg::*;
#(
   parameter int FRAME_LEN = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic       in_bit,
   output logic       in_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_pair,
   output logic       out_sof,
   output logic       out_eof,
   output logic       busy
);

   localparam int               CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

   enc_state_e       state;
   logic [1:0]       sr;
   logic [1:0]       sr_next;
   logic [CNT_W-1:0] bit_cnt;
   logic             tail_cnt;
   logic             d;
   logic             slot_free;
   logic             advance;
   sym_t             sym;

   assign slot_free = !out_valid || out_ready;
   assign in_ready  = rst_n && (state == ST_DATA) && slot_free;
   assign d         = (state == ST_DATA) ? in_bit : 1'b0;
   // Tail symbols need no upstream handshake, only room in the output slot.
   assign advance   = (state == ST_DATA) ? (in_valid && in_ready) : slot_free;
   assign busy      = (bit_cnt != '0) || (state == ST_TAIL);

   enc_branch u_branch (
      .sr      (sr),
      .d       (d),
      .sym     (sym),
      .sr_next (sr_next)
   );

   // Output register stage
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_DATA;
         sr        <= 2'b00;
         bit_cnt   <= '0;
         tail_cnt  <= 1'b0;
         out_valid <= 1'b0;
         out_pair  <= 2'b00;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
      end else if (advance) begin
         out_valid <= 1'b1;
         out_pair  <= sym;
         sr        <= sr_next;
         if (state == ST_DATA) begin
            out_sof <= (bit_cnt == '0);
            out_eof <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
               bit_cnt  <= '0;
               tail_cnt <= 1'b0;
               state    <= ST_TAIL;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end else begin
            out_sof <= 1'b0;
            out_eof <= tail_cnt;
            if (tail_cnt) begin
               tail_cnt <= 1'b0;
               state    <= ST_DATA;
            end else begin
               tail_cnt <= 1'b1;
            end
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/conv_encoder_k3.md
# conv_encoder_k3

Frame-based rate-1/2, constraint-length-3 convolutional encoder with valid/ready on both sides. It accepts one data bit per cycle and emits one 2-bit coded symbol per cycle. After each frame it appends two zero tail bits, so the trellis always terminates in state 00. It is the transmit end of the link decoded by the Viterbi branch-metric/ACS path, and it doubles as the golden stimulus source for decoder benches.

## Interface
- FRAME_LEN, 256: data bits per frame; legal range ≥1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream bit available.
- in_bit  in  1  data bit.
- in_ready  out  1  encoder accepts in_bit this cycle.
- out_valid  out  1  out_pair holds a symbol.
- out_ready  in  1  downstream consumes the symbol.
- out_pair  out  2  coded symbol: [1] = G0 output, [0] = G1 output.
- out_sof  out  1  qualifies the first symbol of a frame.
- out_eof  out  1  qualifies the last symbol of a frame (second tail symbol).
- busy  out  1  a frame is in progress: bit count ≠ 0 or the FSM is in TAIL.

## Operation
- Encoder state: sr = {s1, s0}. s1 is the previous input bit; s0 is the bit before that.
- Generators: G0 = 111, G1 = 101.
  - out_pair[1] = d ^ s1 ^ s0.
  - out_pair[0] = d ^ s0.
  - On each symbol generation, the next sr = {d, s1}.
- FSM states:
  - ST_DATA: d = in_bit. A transfer occurs when in_valid & in_ready.
  - ST_TAIL: d = 0. No input is consumed.
- Output slot is a single register. slot_free = !out_valid | out_ready.
- in_ready = (state == ST_DATA) & slot_free. It is forced to 0 while rst_n = 0.
- ST_DATA behaviour:
  - Each transfer loads the output register and increments bit_cnt.
  - out_sof = (bit_cnt == 0).
  - When a transfer happens with bit_cnt == FRAME_LEN-1: bit_cnt goes to 0, tail_cnt goes to 0, and the FSM moves to ST_TAIL.
- ST_TAIL behaviour:
  - Each cycle with slot_free, load one tail symbol and increment tail_cnt.
  - The second tail symbol sets out_eof. The FSM then returns to ST_DATA.
  - sr is 00 again at this point.
- Backpressure: while out_valid & !out_ready, out_pair, out_sof and out_eof hold stable and no state advances.
- Boundary cases:
  - FRAME_LEN = 1: the only data symbol carries out_sof. out_eof appears on the second tail symbol.
  - out_sof and out_eof are never asserted on the same symbol.
  - Reset mid-frame or mid-tail discards the partial frame. The next accepted bit starts a new frame with out_sof, from sr = 00.

## Timing
- Reset values: out_valid = 0, out_pair = 00, out_sof = 0, out_eof = 0, busy = 0, sr = 00, bit_cnt = 0, tail_cnt = 0, state = ST_DATA.
- in_ready is 1 in the first cycle after rst_n rises.
- Latency: a bit accepted at edge n appears on out_pair after edge n (one-cycle register).
- Throughput: with out_ready held high, a frame of N bits produces N+2 symbols in N+2 consecutive cycles. in_ready is low for exactly the 2 tail cycles.
- bit_cnt width is $clog2(FRAME_LEN), minimum 1. tail_cnt width is 1.
- Counters never wrap mid-frame. bit_cnt returns to 0 only at the frame boundary or on reset.

## Structure
- Shared package viterbi_pkg holds:
  - K = 3, G0 = 3'b111, G1 = 3'b101.
  - typedef enc_state_e {ST_DATA, ST_TAIL}.
  - typedef logic [1:0] sym_t.
  - These are shared with the decoder's branch-metric units.
- One sub-module, enc_branch: purely combinational. Inputs sr and d; outputs sym_t and next sr.
  - It is reusable by decoder reference models.
  - The FSM, counters and output register live in conv_encoder_k3.

## Test plan
- FRAME_LEN = 4, input bits 1,0,1,1 with out_ready = 1 → out_pair 11,10,00,01,01,11 on consecutive cycles. out_sof on the first symbol, out_eof on the sixth, in_ready low during cycles 5–6.
- Same frame with out_ready toggling 1,0 every cycle → identical symbol sequence. Each symbol is held stable while out_ready = 0; no bits are lost or duplicated.
- Two back-to-back FRAME_LEN = 4 frames (1011 then 0000) → the second frame starts with out_sof and emits 00,00,00,00,00,00.
- FRAME_LEN = 1, input 1 → symbols 11,10,11. out_sof on the first, out_eof on the third.
- Reset asserted after 2 of 4 bits, then frame 1011 → output is 11,10,00,01,01,11 with out_sof on the first symbol. busy = 0 in the cycle after reset.
- in_valid gapped (bits on every third cycle) → same symbols as the first scenario. out_valid pulses only after accepted bits; tail symbols follow immediately after the 4th bit.
